// File: rtl/fp_mac_seq_pkg.sv
// Shared types and constants for the sequenced FP multiply-accumulate controller.
// Covers the FSM state encoding, the operation mode codes, and the counter load helper.
package fp_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_ADD_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [1:0] MODE_MUL = 2'b00;
  localparam logic [1:0] MODE_ADD = 2'b01;
  localparam logic [1:0] MODE_MAC = 2'b10;
  localparam logic [1:0] MODE_ACC = 2'b11;

  // A wait of N cycles loads N-1: the counter sits at zero during the last cycle.
  function automatic logic [3:0] wait_load(input int lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/fp_mac_seq_latency_counter.sv
// Loadable 4-bit down-counter timing the multiplier and adder wait states.
// The expired flag is high whenever the count has reached zero.
module latency_counter (
  input  logic       clock,
  input  logic       aclr_n,
  input  logic       clk_en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] count;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      count <= 4'd0;
    end else if (clk_en) begin
      if (load) begin
        count <= load_val;
      end else if (count != 4'd0) begin
        count <= count - 4'd1;
      end
    end
  end

  assign expired = (count == 4'd0);

endmodule

// File: rtl/fp_mac_seq.sv
// Sequencer for externally pipelined FP multiplier and adder cores: MUL, ADD, MAC, ACC.
// Handshake: start is taken only in IDLE with clk_en=1; done pulses one cycle with result valid.
module fp_mac_seq
  import fp_mac_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 5,
  parameter int ADD_LATENCY = 7
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  acc_clr,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic [DATA_WIDTH-1:0] datab,
  input  logic [DATA_WIDTH-1:0] datac,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  output logic                  mul_en,
  input  logic [DATA_WIDTH-1:0] mul_result,
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  output logic                  add_en,
  input  logic [DATA_WIDTH-1:0] add_result,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [1:0]            dbg_state
);

  localparam logic [3:0] MUL_LOAD = wait_load(MUL_LATENCY);
  localparam logic [3:0] ADD_LOAD = wait_load(ADD_LATENCY);

  state_t                state;
  logic [DATA_WIDTH-1:0] a_q, b_q, c_q, prod_q, acc_q, result_q;
  logic [1:0]            mode_q;
  logic                  clr_q;
  logic                  mul_en_q, add_en_q, busy_q, done_q;
  logic                  cnt_load, cnt_expired;
  logic [3:0]            cnt_val;
  logic [DATA_WIDTH-1:0] acc_eff;

  latency_counter u_cnt (
    .clock    (clock),
    .aclr_n   (aclr_n),
    .clk_en   (clk_en),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expired  (cnt_expired)
  );

  // The counter is (re)loaded on every edge that enters a wait state.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = MUL_LOAD;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          cnt_val  = (mode == MODE_ADD) ? ADD_LOAD : MUL_LOAD;
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_expired && (mode_q != MODE_MUL)) begin
          cnt_load = 1'b1;
          cnt_val  = ADD_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      mode_q   <= MODE_MUL;
      clr_q    <= 1'b0;
      mul_en_q <= 1'b0;
      add_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q    <= dataa;
            b_q    <= datab;
            c_q    <= datac;
            mode_q <= mode;
            clr_q  <= acc_clr;
            busy_q <= 1'b1;
            if (mode == MODE_ADD) begin
              add_en_q <= 1'b1;
              state    <= ST_ADD_WAIT;
            end else begin
              mul_en_q <= 1'b1;
              state    <= ST_MUL_WAIT;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (cnt_expired) begin
            mul_en_q <= 1'b0;
            prod_q   <= mul_result;
            if (mode_q == MODE_MUL) begin
              result_q <= mul_result;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= ST_DONE;
            end else begin
              add_en_q <= 1'b1;
              state    <= ST_ADD_WAIT;
            end
          end
        end
        ST_ADD_WAIT: begin
          if (cnt_expired) begin
            add_en_q <= 1'b0;
            result_q <= add_result;
            if (mode_q == MODE_ACC) acc_q <= add_result;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= ST_DONE;
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // acc_clr substitutes +0.0 for the accumulator on this operation only.
  assign acc_eff = clr_q ? '0 : acc_q;

  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign add_a     = (mode_q == MODE_ADD) ? a_q : prod_q;
  assign add_b     = (mode_q == MODE_ACC) ? acc_eff : c_q;
  assign mul_en    = mul_en_q & clk_en;
  assign add_en    = add_en_q & clk_en;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_fp_mac_seq.sv
// Bench for fp_mac_seq: behavioural FP core models plus an integer-valued reference model.
module tb_fp_mac_seq;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int ADD_LAT = 7;
  localparam int MUL_IDX = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam int ADD_IDX = (ADD_LAT > 1) ? ADD_LAT - 2 : 0;
  localparam logic [1:0] M_MUL = 2'b00, M_ADD = 2'b01, M_MAC = 2'b10, M_ACC = 2'b11;

  logic         clock, aclr_n, clk_en, start, acc_clr;
  logic [1:0]   mode, dbg_state;
  logic [W-1:0] dataa, datab, datac;
  logic [W-1:0] mul_a, mul_b, mul_result, add_a, add_b, add_result, result;
  logic         mul_en, add_en, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int acc_m    = 0;
  logic [W-1:0] exp_q[$];

  fp_mac_seq #(.DATA_WIDTH(W), .MUL_LATENCY(MUL_LAT), .ADD_LATENCY(ADD_LAT)) dut (
    .clock(clock), .aclr_n(aclr_n), .clk_en(clk_en), .start(start), .mode(mode),
    .acc_clr(acc_clr), .dataa(dataa), .datab(datab), .datac(datac),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_result(mul_result),
    .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_result(add_result),
    .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- float helpers (exact for integer values below 2^24) ----------------
  function automatic logic [31:0] int2f(input int v);
    logic [31:0] m, f;
    int p;
    if (v == 0) return 32'h0;
    m = 32'((v < 0) ? -v : v);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    f = (m << (23 - p)) & 32'h007F_FFFF;
    return {(v < 0), 8'(127 + p), f[22:0]};
  endfunction

  function automatic int f2int(input logic [31:0] bits);
    logic [31:0] mant;
    int p, val;
    if (bits[30:23] == 8'd0) return 0;
    p = int'(bits[30:23]) - 127;
    if (p < 0 || p > 23) return 0;
    mant = {8'd0, 1'b1, bits[22:0]};
    val = int'(mant >> (23 - p));
    return bits[31] ? -val : val;
  endfunction

  // ---------------- external core models ----------------
  logic [W-1:0] mul_pipe[0:15];
  logic [W-1:0] add_pipe[0:15];
  logic [W-1:0] mul_comb, add_comb;

  assign mul_comb   = int2f(f2int(mul_a) * f2int(mul_b));
  assign add_comb   = int2f(f2int(add_a) + f2int(add_b));
  assign mul_result = (MUL_LAT == 1) ? mul_comb : mul_pipe[MUL_IDX];
  assign add_result = (ADD_LAT == 1) ? add_comb : add_pipe[ADD_IDX];

  always @(posedge clock) begin
    if (mul_en) begin
      mul_pipe[0] <= mul_comb;
      for (int i = 1; i < 16; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    if (add_en) begin
      add_pipe[0] <= add_comb;
      for (int i = 1; i < 16; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [1:0] m, input int a, input int b, input int c,
                        input logic clr, input int stall_at, input int stall_len,
                        input bit poke_busy, output int lat, output logic [W-1:0] res,
                        output bit mul_seen, output bit add_seen, output bit pulse_ok);
    mode = m; dataa = int2f(a); datab = int2f(b); datac = int2f(c);
    acc_clr = clr; start = 1'b1;
    lat = 0; res = '0; mul_seen = 0; add_seen = 0; pulse_ok = 0;
    @(posedge clock);
    for (int n = 1; n <= 80 && lat == 0; n++) begin
      @(negedge clock);
      if (n == 1) start = 1'b0;
      if (stall_len > 0 && n == stall_at) clk_en = 1'b0;
      if (stall_len > 0 && n == stall_at + stall_len) clk_en = 1'b1;
      if (poke_busy && n == 3) begin
        start = 1'b1; mode = M_ADD; dataa = $urandom; datab = $urandom; datac = $urandom;
      end
      if (poke_busy && n == 4) start = 1'b0;
      #1;
      if (mul_en) mul_seen = 1;
      if (add_en) add_seen = 1;
      if (done) begin lat = n; res = result; end
    end
    clk_en = 1'b1;
    start = 1'b0;
    @(negedge clock);
    #1;
    pulse_ok = (done === 1'b0) && (result === res);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    aclr_n = 1'b0; clk_en = 1'b1; start = 1'b0; mode = M_MUL; acc_clr = 1'b0;
    dataa = '0; datab = '0; datac = '0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else n_pass++;
    n_checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (mul_en !== 1'b0 || add_en !== 1'b0)
      $display("FAIL reset_enables: got mul_en=%b add_en=%b expected 0 0", mul_en, add_en); else n_pass++;
    @(negedge clock);
    aclr_n = 1'b1;
  endtask

  task automatic test_mac;
    int lat; logic [W-1:0] res; bit ms, as, pk;
    exp_q.push_back(32'h40E0_0000);
    run_op(M_MAC, 2, 3, 1, 1'b0, 0, 0, 0, lat, res, ms, as, pk);
    n_checks++; if (lat !== MUL_LAT + ADD_LAT + 1) $display("FAIL mac_latency: got %0d expected %0d", lat, MUL_LAT + ADD_LAT + 1); else n_pass++;
    n_checks++; if (res !== exp_q[0]) $display("FAIL mac_result: got %h expected %h", res, exp_q[0]); else n_pass++;
    void'(exp_q.pop_front());
    n_checks++; if (!pk) $display("FAIL mac_pulse: got done=%b after pulse expected 0 and held result", done); else n_pass++;
  endtask

  task automatic test_mul;
    int lat; logic [W-1:0] res; bit ms, as, pk;
    run_op(M_MUL, 2, 3, 9, 1'b0, 0, 0, 0, lat, res, ms, as, pk);
    n_checks++; if (lat !== MUL_LAT + 1) $display("FAIL mul_latency: got %0d expected %0d", lat, MUL_LAT + 1); else n_pass++;
    n_checks++; if (res !== 32'h40C0_0000) $display("FAIL mul_result: got %h expected 40c00000", res); else n_pass++;
    n_checks++; if (as !== 1'b0) $display("FAIL mul_add_en: got %b expected 0", as); else n_pass++;
    n_checks++; if (ms !== 1'b1) $display("FAIL mul_mul_en: got %b expected 1", ms); else n_pass++;
  endtask

  task automatic test_add;
    int lat; logic [W-1:0] res; bit ms, as, pk;
    run_op(M_ADD, 2, 5, 1, 1'b0, 0, 0, 0, lat, res, ms, as, pk);
    n_checks++; if (lat !== ADD_LAT + 1) $display("FAIL add_latency: got %0d expected %0d", lat, ADD_LAT + 1); else n_pass++;
    n_checks++; if (res !== 32'h4040_0000) $display("FAIL add_result: got %h expected 40400000", res); else n_pass++;
    n_checks++; if (ms !== 1'b0) $display("FAIL add_mul_en: got %b expected 0", ms); else n_pass++;
  endtask

  task automatic test_acc;
    int lat; logic [W-1:0] res; bit ms, as, pk;
    run_op(M_ACC, 2, 3, 0, 1'b1, 0, 0, 0, lat, res, ms, as, pk);
    n_checks++; if (res !== 32'h40C0_0000) $display("FAIL acc_first: got %h expected 40c00000", res); else n_pass++;
    n_checks++; if (lat !== MUL_LAT + ADD_LAT + 1) $display("FAIL acc_latency: got %0d expected %0d", lat, MUL_LAT + ADD_LAT + 1); else n_pass++;
    run_op(M_ACC, 2, 3, 0, 1'b0, 0, 0, 0, lat, res, ms, as, pk);
    n_checks++; if (res !== 32'h4140_0000) $display("FAIL acc_second: got %h expected 41400000", res); else n_pass++;
    acc_m = 12;
  endtask

  task automatic test_mac_stall;
    int lat; logic [W-1:0] res; bit ms, as, pk;
    run_op(M_MAC, 2, 3, 1, 1'b0, MUL_LAT + 3, 3, 1, lat, res, ms, as, pk);
    n_checks++; if (lat !== MUL_LAT + ADD_LAT + 4) $display("FAIL stall_latency: got %0d expected %0d", lat, MUL_LAT + ADD_LAT + 4); else n_pass++;
    n_checks++; if (res !== 32'h40E0_0000) $display("FAIL stall_result: got %h expected 40e00000", res); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    int lat, dones; logic [W-1:0] res; bit ms, as, pk;
    mode = M_MUL; dataa = int2f(5); datab = int2f(7); acc_clr = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    #2 aclr_n = 1'b0;
    #1;
    n_checks++; if (result !== 32'h0) $display("FAIL abort_result: got %h expected 0", result); else n_pass++;
    n_checks++; if (busy !== 1'b0 || mul_en !== 1'b0) $display("FAIL abort_busy: got busy=%b mul_en=%b expected 0 0", busy, mul_en); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL abort_state: got %0d expected 0", dbg_state); else n_pass++;
    @(negedge clock); aclr_n = 1'b1;
    dones = 0;
    repeat (12) begin @(negedge clock); #1; if (done) dones++; end
    n_checks++; if (dones !== 0) $display("FAIL abort_no_done: got %0d done cycles expected 0", dones); else n_pass++;
    acc_m = 0;
    run_op(M_MUL, 2, 3, 0, 1'b0, 0, 0, 0, lat, res, ms, as, pk);
    n_checks++; if (lat !== MUL_LAT + 1) $display("FAIL abort_mul_latency: got %0d expected %0d", lat, MUL_LAT + 1); else n_pass++;
    n_checks++; if (res !== 32'h40C0_0000) $display("FAIL abort_mul_result: got %h expected 40c00000", res); else n_pass++;
    run_op(M_ACC, 4, 5, 0, 1'b0, 0, 0, 0, lat, res, ms, as, pk);
    acc_m = acc_m + 20;
    n_checks++; if (res !== int2f(acc_m)) $display("FAIL abort_acc_lost: got %h expected %h", res, int2f(acc_m)); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat, a, b, c, exp_lat, v;
    logic [W-1:0] res; bit ms, as, pk;
    logic [1:0] m; logic clr;
    for (int t = 0; t < 12; t++) begin
      m = 2'($urandom_range(0, 3));
      a = int'($urandom_range(0, 40)) - 20;
      b = int'($urandom_range(0, 40)) - 20;
      c = int'($urandom_range(0, 40)) - 20;
      clr = ($urandom_range(0, 3) == 0);
      case (m)
        M_MUL: begin v = a * b; exp_lat = MUL_LAT + 1; end
        M_ADD: begin v = a + c; exp_lat = ADD_LAT + 1; end
        M_MAC: begin v = a * b + c; exp_lat = MUL_LAT + ADD_LAT + 1; end
        default: begin
          acc_m = (clr ? 0 : acc_m) + a * b;
          v = acc_m; exp_lat = MUL_LAT + ADD_LAT + 1;
        end
      endcase
      exp_q.push_back(int2f(v));
      run_op(m, a, b, c, clr, 0, 0, 0, lat, res, ms, as, pk);
      n_checks++; if (lat !== exp_lat) $display("FAIL b2b_latency[%0d]: got %0d expected %0d", t, lat, exp_lat); else n_pass++;
      n_checks++; if (res !== exp_q[0]) $display("FAIL b2b_result[%0d] mode %0d: got %h expected %h", t, m, res, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mac();
    test_mul();
    test_add();
    test_acc();
    test_mac_stall();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
